rv: RTL and testbench

//  Minimal multicycle RV32I-subset CPU with private byte-addressed memory and register file.

---
 rtl/rv_pkg.sv | 35 +++
 rtl/rv_mem.sv | 38 +++
 rtl/rv_regfile.sv | 24 ++
 rtl/rv.sv | 135 +++++++++++++
 tb/tb_rv.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the rv RV32I-subset core: opcodes, funct3 codes, FSM states.
// Also holds the load-extension helper used in the MEM state.
package rv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_ADD = 3'b000;

    typedef enum logic [2:0] {FETCH, DECODE, MEM, WB, HALT} state_t;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] v;
        case (f3)
            F3_LB:   v = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   v = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  v = {24'd0, raw[7:0]};
            F3_LHU:  v = {16'd0, raw[15:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rv_mem.sv
// Byte-addressed little-endian memory: 4-byte combinational read, 1/2/4-byte synchronous write.
// Zero read latency, write lands on the clock edge; every byte address wraps modulo MEM_BYTES; no backpressure.
module rv_mem #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    logic [7:0] mem [0:MEM_BYTES-1];

    // Each byte lane wraps independently, so misaligned words straddle the top cleanly.
    function automatic logic [AW-1:0] bidx(input logic [31:0] a, input logic [1:0] k);
        logic [31:0] s;
        s = (a + {30'd0, k}) % 32'(MEM_BYTES);
        return AW'(s);
    endfunction

    always_comb begin
        rdata = '0;
        for (int k = 0; k < 4; k++)
            rdata[8*k +: 8] = mem[bidx(addr, 2'(k))];
    end

    always_ff @(posedge clk) begin
        if (we)
            for (int k = 0; k < 4; k++)
                if (k < int'(size))
                    mem[bidx(addr, 2'(k))] <= wdata[8*k +: 8];
    end

endmodule

// File: rtl/rv_regfile.sv
// 32x32 register file, two combinational read ports and one synchronous write port; x0 is hardwired zero.
// Zero read latency, write on the clock edge; no backpressure.
module rv_regfile (
    input  logic        clk,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [0:31];

    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

    always_ff @(posedge clk) begin
        if (we && wa != 5'd0)
            regs[wa] <= wd;
    end

endmodule

// File: rtl/rv.sv
// Multicycle RV32I-subset core (LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI, ADD/SUB, LUI); RV_ILLEGAL_HALT_EN parks on illegal ops.
// 3 cycles per ALU op or store, 4 per load; self-contained, no backpressure.
module rv
    import rv_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [31:0] bus,
    output logic [31:0] addr
);

    state_t      state, state_nxt;
    logic [31:0] pc, ir, res;
    logic [31:0] mem_rdata, rs1_val, rs2_val, alu, ld_val, bus_val, addr_int;
    logic        mem_we, rf_we;
    logic [2:0]  st_size;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_u;
    logic        is_load, is_store, is_addi, is_op, is_lui, legal;

    rv_mem #(.MEM_BYTES(MEM_BYTES)) m (
        .clk(clk), .addr(addr_int), .we(mem_we), .size(st_size),
        .wdata(rs2_val), .rdata(mem_rdata)
    );

    rv_regfile r (
        .clk(clk), .ra1(rs1), .ra2(rs2), .rd1(rs1_val), .rd2(rs2_val),
        .we(rf_we), .wa(rd), .wd(res)
    );

    assign opc   = ir[6:0];
    assign rd    = ir[11:7];
    assign f3    = ir[14:12];
    assign rs1   = ir[19:15];
    assign rs2   = ir[24:20];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_u = {ir[31:12], 12'd0};

    always_comb begin
        is_load  = (opc == OPC_LOAD) && (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        is_store = (opc == OPC_STORE) && (f3 inside {F3_SB, F3_SH, F3_SW});
        is_addi  = (opc == OPC_OPIMM) && (f3 == F3_ADD);
        is_op    = (opc == OPC_OP) && (f3 == F3_ADD) &&
                   (ir[31:25] == 7'b0000000 || ir[31:25] == 7'b0100000);
        is_lui   = (opc == OPC_LUI);
        legal    = is_load || is_store || is_addi || is_op || is_lui;
    end

    always_comb begin
        alu = '0;
        if (is_load || is_addi) alu = rs1_val + imm_i;
        else if (is_store)      alu = rs1_val + imm_s;
        else if (is_op)         alu = ir[30] ? rs1_val - rs2_val : rs1_val + rs2_val;
        else if (is_lui)        alu = imm_u;
    end

    assign ld_val  = load_ext(f3, mem_rdata);
    assign st_size = (f3 == F3_SB) ? 3'd1 : (f3 == F3_SH) ? 3'd2 : 3'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                if (is_load || is_store) state_nxt = MEM;
`ifdef RV_ILLEGAL_HALT_EN
                else if (!legal)         state_nxt = HALT;
`endif
                else                     state_nxt = WB;
            end
            MEM:    state_nxt = is_load ? WB : FETCH;
            WB:     state_nxt = FETCH;
`ifdef RV_ILLEGAL_HALT_EN
            HALT:   state_nxt = HALT;
`endif
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        addr_int = pc;
        bus_val  = '0;
        mem_we   = 1'b0;
        rf_we    = 1'b0;
        case (state)
            FETCH:  bus_val = mem_rdata;
            DECODE: bus_val = alu;
            MEM: begin
                addr_int = res;
                mem_we   = is_store;
                bus_val  = is_store ? rs2_val : ld_val;
            end
            WB: begin
                bus_val = res;
                rf_we   = legal;
            end
`ifdef RV_ILLEGAL_HALT_EN
            HALT:   bus_val = ir;
`endif
            default: ;
        endcase
    end

    // res carries the effective address into MEM and the writeback value into WB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc  <= '0;
            ir  <= '0;
            res <= '0;
        end else begin
            case (state)
                FETCH:  ir <= mem_rdata;
                DECODE: res <= alu;
                MEM:    if (is_load) res <= ld_val;
                        else         pc  <= pc + 32'd4;
                WB:     pc <= pc + 32'd4;
                default: ;
            endcase
        end
    end

    assign addr = rst ? addr_int : '0;
    assign bus  = rst ? bus_val  : '0;

endmodule

// File: tb/tb_rv.sv
// Program-level bench for rv: preloads memory/registers, runs short programs and scoreboards every write.
module tb_rv;
    import rv_pkg::*;

    localparam int MB = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire  [31:0] bus;
    logic [31:0] addr;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          is_mem;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  n;
    } exp_t;
    exp_t sb_q[$];

    rv #(.MEM_BYTES(MB)) dut (.clk(clk), .rst(rst), .bus(bus), .addr(addr));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic put_word(input int a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) dut.m.mem[(a + k) % MB] <= w[8*k +: 8];
    endtask

    task automatic exp_reg(input logic [4:0] r, input logic [31:0] v);
        sb_q.push_back('{is_mem: 1'b0, a: {27'd0, r}, d: v, n: 3'd0});
    endtask

    task automatic exp_mem(input logic [31:0] a, input logic [31:0] v, input logic [2:0] n);
        sb_q.push_back('{is_mem: 1'b1, a: a, d: v, n: n});
    endtask

    // Abort whatever runs, then clear memory and registers while held in reset.
    task automatic prep();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < MB; i++) dut.m.mem[i] <= 8'h00;
        for (int i = 0; i < 32; i++) dut.r.regs[i] <= 32'd0;
    endtask

    task automatic go();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && (dut.r.we || dut.m.we)) begin
            check("sb_write_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_kind", 32'(dut.m.we), 32'(e.is_mem));
                if (dut.m.we) begin
                    check("sb_mem_addr", dut.m.addr, e.a);
                    check("sb_mem_data", dut.m.wdata, e.d);
                    check("sb_mem_size", 32'(dut.m.size), 32'(e.n));
                end else begin
                    check("sb_reg_idx", 32'(dut.r.wa), e.a);
                    check("sb_reg_data", dut.r.wd, e.d);
                end
            end
        end
    end

    initial begin
        #1 rst = 1'b0;

        // Store/load chain through x1.
        prep();
        put_word(0, 32'h0010A023);
        put_word(4, 32'h0000A083);
        dut.r.regs[1] <= 32'd42;
        exp_mem(32'd42, 32'd42, 3'd4);
        exp_reg(5'd1, 32'd42);
        go();
        run(2);
        check("t1_store_mem_addr", addr, 32'd42);
        check("t1_store_bus", bus, 32'd42);
        run(3);
        check("t1_load_mem_addr", addr, 32'd42);
        check("t1_load_bus", bus, 32'd42);
        run(2);
        check("t1_mem42", 32'(dut.m.mem[42]), 32'd42);
        check("t1_mem43", 32'(dut.m.mem[43]), 32'd0);
        check("t1_mem44", 32'(dut.m.mem[44]), 32'd0);
        check("t1_mem45", 32'(dut.m.mem[45]), 32'd0);
        check("t1_x1", dut.r.regs[1], 32'd42);
        drain("t1_drain");

        // ALU ops, x0 discard, wrap-around arithmetic.
        prep();
        put_word(0,  enc_i(12'hFFF, 5'd0, 3'd0, 5'd2, 7'b0010011));
        put_word(4,  enc_i(12'd5,   5'd0, 3'd0, 5'd0, 7'b0010011));
        put_word(8,  {20'h80000, 5'd5, 7'b0110111});
        put_word(12, enc_r(7'h00, 5'd5, 5'd5, 5'd6));
        put_word(16, enc_r(7'h20, 5'd2, 5'd0, 5'd7));
        put_word(20, enc_i(12'hFFF, 5'd5, 3'd0, 5'd8, 7'b0010011));
        exp_reg(5'd2, 32'hFFFF_FFFF);
        exp_reg(5'd0, 32'd5);
        exp_reg(5'd5, 32'h8000_0000);
        exp_reg(5'd6, 32'h0000_0000);
        exp_reg(5'd7, 32'h0000_0001);
        exp_reg(5'd8, 32'h7FFF_FFFF);
        go();
        run(3);
        check("t2_addi_neg", dut.r.regs[2], 32'hFFFF_FFFF);
        run(3);
        check("t2_x0_stays_zero", dut.r.regs[0], 32'd0);
        run(12);
        check("t2_add_wrap", dut.r.regs[6], 32'd0);
        check("t2_sub", dut.r.regs[7], 32'd1);
        check("t2_pc", dut.pc, 32'd24);
        drain("t2_drain");

        // Load extension and a misaligned word load.
        prep();
        dut.m.mem[100] <= 8'h80;
        dut.m.mem[101] <= 8'h90;
        dut.m.mem[102] <= 8'h12;
        dut.m.mem[103] <= 8'h34;
        dut.m.mem[104] <= 8'h56;
        dut.r.regs[1] <= 32'd100;
        put_word(0,  enc_i(12'd0, 5'd1, 3'd0, 5'd3,  7'b0000011));
        put_word(4,  enc_i(12'd0, 5'd1, 3'd4, 5'd4,  7'b0000011));
        put_word(8,  enc_i(12'd0, 5'd1, 3'd1, 5'd9,  7'b0000011));
        put_word(12, enc_i(12'd0, 5'd1, 3'd5, 5'd10, 7'b0000011));
        put_word(16, enc_i(12'd1, 5'd1, 3'd2, 5'd11, 7'b0000011));
        exp_reg(5'd3,  32'hFFFF_FF80);
        exp_reg(5'd4,  32'h0000_0080);
        exp_reg(5'd9,  32'hFFFF_9080);
        exp_reg(5'd10, 32'h0000_9080);
        exp_reg(5'd11, 32'h5634_1290);
        go();
        run(20);
        check("t3_lb", dut.r.regs[3], 32'hFFFF_FF80);
        check("t3_lbu", dut.r.regs[4], 32'h0000_0080);
        check("t3_lh", dut.r.regs[9], 32'hFFFF_9080);
        check("t3_lhu", dut.r.regs[10], 32'h0000_9080);
        check("t3_lw_misaligned", dut.r.regs[11], 32'h5634_1290);
        drain("t3_drain");

        // Store sizes and address wrap at the top of memory.
        prep();
        dut.r.regs[1] <= 32'(MB - 2);
        dut.r.regs[2] <= 32'h1122_3344;
        put_word(0, enc_s(12'd0,   5'd2, 5'd1, 3'd2));
        put_word(4, enc_s(12'd200, 5'd2, 5'd0, 3'd1));
        put_word(8, enc_s(12'd204, 5'd2, 5'd0, 3'd0));
        exp_mem(32'(MB - 2), 32'h1122_3344, 3'd4);
        exp_mem(32'd200,     32'h1122_3344, 3'd2);
        exp_mem(32'd204,     32'h1122_3344, 3'd1);
        go();
        run(9);
        check("t4_wrap_b0", 32'(dut.m.mem[MB-2]), 32'h44);
        check("t4_wrap_b1", 32'(dut.m.mem[MB-1]), 32'h33);
        check("t4_wrap_b2", 32'(dut.m.mem[0]), 32'h22);
        check("t4_wrap_b3", 32'(dut.m.mem[1]), 32'h11);
        check("t4_sh_lo", 32'(dut.m.mem[200]), 32'h44);
        check("t4_sh_hi", 32'(dut.m.mem[201]), 32'h33);
        check("t4_sh_over", 32'(dut.m.mem[202]), 32'h00);
        check("t4_sb", 32'(dut.m.mem[204]), 32'h44);
        check("t4_sb_over", 32'(dut.m.mem[205]), 32'h00);
        check("t4_pc", dut.pc, 32'd12);
        drain("t4_drain");

        // Reset in the MEM state of a store, then refetch.
        prep();
        dut.r.regs[1] <= 32'd42;
        dut.r.regs[2] <= 32'hDEAD_BEEF;
        put_word(0, enc_s(12'd0, 5'd2, 5'd1, 3'd2));
        go();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t5_in_mem_addr", addr, 32'd42);
        rst = 1'b0;
        #1;
        check("t5_rst_addr", addr, 32'd0);
        check("t5_rst_bus", bus, 32'd0);
        check("t5_rst_pc", dut.pc, 32'd0);
        check("t5_rst_ir", dut.ir, 32'd0);
        check("t5_rst_state", 32'(dut.state), 32'(FETCH));
        run(2);
        check("t5_no_store", {dut.m.mem[45], dut.m.mem[44], dut.m.mem[43], dut.m.mem[42]}, 32'd0);
        exp_mem(32'd42, 32'hDEAD_BEEF, 3'd4);
        rst = 1'b1;
        #1;
        check("t5_refetch_addr", addr, 32'd0);
        check("t5_refetch_bus", bus, 32'h0020_A023);
        run(3);
        check("t5_store_done", {dut.m.mem[45], dut.m.mem[44], dut.m.mem[43], dut.m.mem[42]}, 32'hDEAD_BEEF);
        drain("t5_drain");

        // Illegal instruction word.
        prep();
        put_word(0, 32'hFFFF_FFFF);
        put_word(4, enc_i(12'd7, 5'd0, 3'd0, 5'd12, 7'b0010011));
`ifdef RV_ILLEGAL_HALT_EN
        go();
        run(3);
        check("t6_halt_pc", dut.pc, 32'd0);
        check("t6_halt_state", 32'(dut.state), 32'(HALT));
        check("t6_halt_addr", addr, 32'd0);
        check("t6_halt_bus", bus, 32'hFFFF_FFFF);
        run(10);
        check("t6_halt_pc_held", dut.pc, 32'd0);
        check("t6_halt_no_wb", dut.r.regs[12], 32'd0);
`else
        exp_reg(5'd12, 32'd7);
        go();
        run(3);
        check("t6_nop_pc", dut.pc, 32'd4);
        check("t6_nop_no_x31", dut.r.regs[31], 32'd0);
        run(3);
        check("t6_next_instr", dut.r.regs[12], 32'd7);
`endif
        drain("t6_drain");

        @(posedge clk);
        #1 rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
